// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared widths and busy-vector sizing for the register file and pipeline control
package reg_file_mp_pkg;
   localparam int DATA_W_DEF  = 32;
   localparam int INDEX_W_DEF = 4;
   localparam int BUSY_W_DEF  = 2**INDEX_W_DEF;
   function automatic int busy_w(input int index_w);
      return 2**index_w;
   endfunction
endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// rf_scoreboard: per-entry busy bits with reserve/clear and post-update lookup for both read ports
import reg_file_mp_pkg::*;
module rf_scoreboard #(
   parameter int INDEX_W  = INDEX_W_DEF,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic               rsv_en,
   input  logic [INDEX_W-1:0] rsv_index,
   input  logic [INDEX_W-1:0] rd0_index,
   input  logic [INDEX_W-1:0] rd1_index,
   output logic               rd0_busy_post,
   output logic               rd1_busy_post
);
   localparam int DEPTH = busy_w(INDEX_W);
   logic [DEPTH-1:0] busy_q, busy_d;
   // reserve is applied after the write clear so it wins on the same index
   always_comb begin
      busy_d = busy_q;
      if (wr_en) busy_d[wr_index] = 1'b0;
      if (rsv_en) busy_d[rsv_index] = 1'b1;
      if (ZERO_REG) busy_d[0] = 1'b0;
   end
   assign rd0_busy_post = busy_d[rd0_index];
   assign rd1_busy_post = busy_d[rd1_index];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) busy_q <= '0;
      else busy_q <= busy_d;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: two-read one-write register file with optional zero entry, write bypass and busy scoreboard
import reg_file_mp_pkg::*;
module reg_file_mp #(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int INDEX_W  = INDEX_W_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [DATA_W-1:0]  wr_data,
   input  logic               rsv_en,
   input  logic [INDEX_W-1:0] rsv_index,
   input  logic               rd0_en,
   input  logic [INDEX_W-1:0] rd0_index,
   input  logic               rd1_en,
   input  logic [INDEX_W-1:0] rd1_index,
   output logic [DATA_W-1:0]  rd0_data,
   output logic [DATA_W-1:0]  rd1_data,
   output logic               rd0_busy,
   output logic               rd1_busy
);
   localparam int DEPTH = busy_w(INDEX_W);
   logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [DATA_W-1:0] rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
   logic rd0_busy_q, rd0_busy_d, rd1_busy_q, rd1_busy_d;
   logic rd0_busy_post, rd1_busy_post;
   logic wr_ok, rd0_zero, rd1_zero, rd0_fwd, rd1_fwd;
   rf_scoreboard #(.INDEX_W(INDEX_W), .ZERO_REG(ZERO_REG)) u_sb (
      .clk(clk), .reset_n(reset_n),
      .wr_en(wr_en), .wr_index(wr_index),
      .rsv_en(rsv_en), .rsv_index(rsv_index),
      .rd0_index(rd0_index), .rd1_index(rd1_index),
      .rd0_busy_post(rd0_busy_post), .rd1_busy_post(rd1_busy_post)
   );
   // the zero entry masks bypass too, so forwarding is never checked first
   always_comb begin
      wr_ok = wr_en && !(ZERO_REG && wr_index == '0);
      rd0_zero = ZERO_REG && rd0_index == '0;
      rd1_zero = ZERO_REG && rd1_index == '0;
      rd0_fwd = BYPASS && wr_en && wr_index == rd0_index;
      rd1_fwd = BYPASS && wr_en && wr_index == rd1_index;
      mem_d = mem_q;
      if (wr_ok) mem_d[wr_index] = wr_data;
      rd0_data_d = !rd0_en ? rd0_data_q : rd0_zero ? '0 : rd0_fwd ? wr_data : mem_q[rd0_index];
      rd1_data_d = !rd1_en ? rd1_data_q : rd1_zero ? '0 : rd1_fwd ? wr_data : mem_q[rd1_index];
      rd0_busy_d = rd0_en ? rd0_busy_post : rd0_busy_q;
      rd1_busy_d = rd1_en ? rd1_busy_post : rd1_busy_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         mem_q      <= '0;
         rd0_data_q <= '0;
         rd1_data_q <= '0;
         rd0_busy_q <= 1'b0;
         rd1_busy_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         rd0_data_q <= rd0_data_d;
         rd1_data_q <= rd1_data_d;
         rd0_busy_q <= rd0_busy_d;
         rd1_busy_q <= rd1_busy_d;
      end
   assign rd0_data = rd0_data_q;
   assign rd1_data = rd1_data_q;
   assign rd0_busy = rd0_busy_q;
   assign rd1_busy = rd1_busy_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench for two configurations (bypass+zero reg, and neither) against a behavioural model
module tb_reg_file_mp;
   logic clk = 1'b0;
   logic reset_n;
   logic we, rs;
   logic [3:0] wi, ri;
   logic [31:0] wd;
   logic [1:0] re;
   logic [1:0][3:0] rix;
   logic [1:0][1:0][31:0] rdd;
   logic [1:0][1:0] rdb;
   int tests = 0, fails = 0;
   logic [31:0] m [2][16];
   logic bz [2][16];
   logic [31:0] ed [2][2];
   logic eb [2][2];

   always #5 clk = ~clk;

   reg_file_mp u0 (
      .clk(clk), .reset_n(reset_n), .wr_en(we), .wr_index(wi), .wr_data(wd),
      .rsv_en(rs), .rsv_index(ri), .rd0_en(re[0]), .rd0_index(rix[0]),
      .rd1_en(re[1]), .rd1_index(rix[1]), .rd0_data(rdd[0][0]), .rd1_data(rdd[0][1]),
      .rd0_busy(rdb[0][0]), .rd1_busy(rdb[0][1])
   );
   reg_file_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u1 (
      .clk(clk), .reset_n(reset_n), .wr_en(we), .wr_index(wi), .wr_data(wd),
      .rsv_en(rs), .rsv_index(ri), .rd0_en(re[0]), .rd0_index(rix[0]),
      .rd1_en(re[1]), .rd1_index(rix[1]), .rd0_data(rdd[1][0]), .rd1_data(rdd[1][1]),
      .rd0_busy(rdb[1][0]), .rd1_busy(rdb[1][1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            m[k][i] = '0;
            bz[k][i] = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            ed[k][p] = '0;
            eb[k][p] = 1'b0;
         end
      end
   endtask

   // instance 0 has zero register and bypass; instance 1 has neither
   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         bit zr, byp, wok;
         logic nb [16];
         zr = (k == 0);
         byp = (k == 0);
         wok = we && !(zr && wi == 0);
         nb = bz[k];
         if (wok) nb[wi] = 1'b0;
         if (rs && !(zr && ri == 0)) nb[ri] = 1'b1;
         for (int p = 0; p < 2; p++)
            if (re[p]) begin
               if (zr && rix[p] == 0) ed[k][p] = '0;
               else if (byp && we && wi == rix[p]) ed[k][p] = wd;
               else ed[k][p] = m[k][rix[p]];
               eb[k][p] = nb[rix[p]];
            end
         if (wok) m[k][wi] = wd;
         bz[k] = nb;
      end
   endtask

   always @(negedge clk)
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("cyc_u%0d_rd%0d_data", k, p), rdd[k][p], ed[k][p]);
            chk($sformatf("cyc_u%0d_rd%0d_busy", k, p), {31'b0, rdb[k][p]}, {31'b0, eb[k][p]});
         end

   task automatic drive(input logic w, input logic [3:0] wix, input logic [31:0] wdat,
                        input logic r, input logic [3:0] rsx,
                        input logic e0, input logic [3:0] i0, input logic e1, input logic [3:0] i1);
      we = w; wi = wix; wd = wdat; rs = r; ri = rsx;
      re = {e1, e0}; rix[0] = i0; rix[1] = i1;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      we = 0; wi = 0; wd = 0; rs = 0; ri = 0; re = 0; rix = '0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 0, 1, 4'(i), 1, 4'(i));
         chk("rst_rd0_data", rdd[0][0], 32'h0);
         chk("rst_rd1_data", rdd[0][1], 32'h0);
         chk("rst_rd0_busy", {31'b0, rdb[0][0]}, 32'h0);
      end
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 5, 0, 0);
      chk("wr5_u0", rdd[0][0], 32'hDEADBEEF);
      chk("wr5_u1", rdd[1][0], 32'hDEADBEEF);
      drive(1, 7, 32'h12345678, 0, 0, 0, 0, 1, 7);
      chk("byp_on", rdd[0][1], 32'h12345678);
      chk("byp_off", rdd[1][1], 32'h0);
      drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
      chk("zero_data", rdd[0][0], 32'h0);
      chk("zero_busy", {31'b0, rdb[0][1]}, 32'h0);
      chk("nozero_data", rdd[1][0], 32'hFFFFFFFF);
      chk("nozero_busy", {31'b0, rdb[1][1]}, 32'h1);
      drive(0, 0, 0, 1, 3, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 3, 0, 0);
      chk("rsv3_busy", {31'b0, rdb[0][0]}, 32'h1);
      drive(1, 3, 32'h33, 1, 3, 1, 3, 0, 0);
      chk("wr_rsv3_busy", {31'b0, rdb[0][0]}, 32'h1);
      chk("wr_rsv3_data_u1", rdd[1][0], 32'h0);
      drive(1, 3, 32'h44, 0, 0, 1, 3, 0, 0);
      chk("wr3_busy", {31'b0, rdb[0][0]}, 32'h0);
      chk("wr3_data_u0", rdd[0][0], 32'h44);
      chk("wr3_data_u1", rdd[1][0], 32'h33);
      drive(0, 0, 0, 1, 3, 0, 0, 0, 0);
      drive(1, 3, 32'h55, 1, 4, 1, 3, 1, 4);
      chk("split_b3", {31'b0, rdb[0][0]}, 32'h0);
      chk("split_b4", {31'b0, rdb[0][1]}, 32'h1);
      drive(0, 0, 0, 0, 0, 1, 5, 1, 5);
      drive(1, 5, 32'h11111111, 0, 0, 0, 5, 0, 5);
      chk("hold_rd0", rdd[0][0], 32'hDEADBEEF);
      chk("hold_rd1", rdd[1][1], 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 1, 5, 1, 5);
      chk("same_idx_p0", rdd[0][0], 32'h11111111);
      chk("same_idx_p1", rdd[0][1], 32'h11111111);
      drive(1, 9, 32'hA5A5A5A5, 1, 9, 1, 9, 1, 5);
      chk("pre_rst_byp", rdd[0][0], 32'hA5A5A5A5);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_rd0", rdd[0][0], 32'h0);
      chk("async_rd1", rdd[0][1], 32'h0);
      chk("async_u1_rd1", rdd[1][1], 32'h0);
      chk("async_busy", {30'b0, rdb[1]}, 32'h0);
      #1 reset_n = 1'b1;
      drive(0, 0, 0, 0, 0, 1, 9, 1, 9);
      chk("post_rst_9", rdd[0][0], 32'h0);
      chk("post_rst_9_u1", rdd[1][1], 32'h0);
      chk("post_rst_busy9", {31'b0, rdb[1][0]}, 32'h0);
      drive(1, 9, 32'h0BADF00D, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 9, 0, 0);
      chk("post_rst_wr9", rdd[1][0], 32'h0BADF00D);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
